register_file: RTL and testbench
================================

Name: register_file

Overview:
- MIPS 32x32 general-purpose register file, directly downstream of the 5-bit write-register mux (rt/rd select) and the 32-bit write-back data mux.
- Two asynchronous read ports feed the decode stage. One synchronous write port is fed by write-back.
- Includes a sequential debug dump engine that streams all 32 registers out over a valid/ready handshake.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W = 32

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- rs_addr  input  ADDR_W  read port A address
- rt_addr  input  ADDR_W  read port B address
- rs_data  output  DATA_W  read port A data
- rt_data  output  DATA_W  read port B data
- we  input  1  write enable
- wr_addr  input  ADDR_W  write address (from 5-bit mux)
- wr_data  input  DATA_W  write data (from 32-bit mux)
- dump_start  input  1  one-cycle pulse; begins dump of r0..r31
- dump_valid  output  1  dump word valid
- dump_ready  input  1  consumer accepts dump word
- dump_idx  output  ADDR_W  index of the current dump word
- dump_data  output  DATA_W  contents of register dump_idx
- dump_busy  output  1  high while the dump engine is not IDLE

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset clears all 32 registers to 0.
- Reset forces the dump FSM to IDLE with dump_valid=0, dump_busy=0, dump_idx=0, dump_data=0.
- Register 0 is hardwired to 0:
  - A write with wr_addr=0 is discarded.
  - Reads of address 0 always return 0.
- Write: when we=1 and wr_addr!=0, regs[wr_addr] is updated with wr_data at the rising edge. Latency is 1 cycle.
- Read: rs_data/rt_data are combinational from the current register contents. Without the bypass feature, a same-cycle write is not visible until the next cycle.
- Dump FSM states are IDLE, SEND, DONE.
  - IDLE: dump_start=1 -> SEND, idx=0.
  - SEND: dump_valid=1. dump_data and dump_idx are registered and stable until the word is accepted.
  - SEND: a transfer occurs when dump_valid && dump_ready. On a transfer, idx increments; on the transfer of idx=31 the FSM goes to DONE instead.
  - SEND: if dump_ready=0, valid, idx and data are held.
  - DONE: one cycle with dump_busy=1, dump_valid=0, then -> IDLE.
  - dump_busy=1 in SEND and DONE.
  - dump_start while not IDLE is ignored.
- Dump data is a snapshot of regs[idx] taken when that word is loaded. A write to that register after loading does not change the offered word. Later indices reflect writes made before they are loaded.
- Normal reads and writes continue unaffected while a dump runs.
- Reset mid-dump aborts immediately: IDLE, dump_valid=0, and the registers are cleared.
- Simultaneous rst and we: rst wins, and all registers read 0 afterwards.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-to-read forwarding.
  - If we=1, wr_addr!=0 and rs_addr==wr_addr, then rs_data=wr_data in the same cycle; the same rule applies to rt.
  - Address 0 is never bypassed.
  - Bypass is suppressed while rst=1.
- Undefined: reads see only stored contents, as described in Behaviour.

Test Plan:
- Reset then read: rst=1 for 1 cycle; read rs_addr=5, rt_addr=31 -> both return 0x00000000.
- Write and read back: write 0xDEADBEEF to r8; next cycle rs_addr=8 -> 0xDEADBEEF. Write 0x12345678 to r0 -> reads of r0 return 0.
- Same-cycle write/read: we=1, wr_addr=9, wr_data=0xA5A5A5A5, rs_addr=9.
  - Without bypass: rs_data = old value (0), then 0xA5A5A5A5 next cycle.
  - With REGFILE_BYPASS_EN: rs_data = 0xA5A5A5A5 in the same cycle.
- Full dump with backpressure: preload rN=N*0x11; pulse dump_start; toggle dump_ready 1/0 every cycle.
  - Exactly 32 transfers, idx 0..31, data N*0x11 with r0=0.
  - Values are held while dump_ready=0.
  - dump_busy drops 1 cycle after the final transfer.
- Snapshot rule: during a dump, with idx=4 stalled (dump_ready=0), write r4=0xFFFF0000 and r20=0xCAFEF00D.
  - idx 4 still outputs its old value.
  - idx 20 outputs 0xCAFEF00D.
- Reset mid-dump: assert rst at idx=10 -> next cycle dump_valid=0, dump_busy=0, all registers read 0. A new dump_start then restarts from idx=0.

Source files
------------

// File: rtl/register_file.sv
// MIPS 32x32 register file: two async read ports, one sync write port, r0 hardwired to zero,
// plus a valid/ready debug dump engine. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, SEND, DONE} dump_state_t;

  dump_state_t       state, state_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] rs_stored, rt_stored;
  logic [ADDR_W-1:0] idx_nxt;
  logic              xfer, last;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs_stored = (rs_addr == '0) ? '0 : regs[rs_addr];
  assign rt_stored = (rt_addr == '0) ? '0 : regs[rt_addr];

`ifdef REGFILE_BYPASS_EN
  logic byp_ok;
  assign byp_ok  = !rst && we && (wr_addr != '0);
  assign rs_data = (byp_ok && rs_addr == wr_addr) ? wr_data : rs_stored;
  assign rt_data = (byp_ok && rt_addr == wr_addr) ? wr_data : rt_stored;
`else
  assign rs_data = rs_stored;
  assign rt_data = rt_stored;
`endif

  assign xfer    = (state == SEND) && dump_ready;
  assign last    = (dump_idx == '1);
  assign idx_nxt = dump_idx + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dump_start) state_nxt = SEND;
      SEND:    if (xfer && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dump_valid = (state == SEND);
    dump_busy  = (state != IDLE);
  end

  // Each word is captured from the array when it is loaded, so later writes to
  // an already-offered register cannot disturb the word held under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_idx  <= '0;
      dump_data <= '0;
    end else if (state == IDLE && dump_start) begin
      dump_idx  <= '0;
      dump_data <= '0;
    end else if (xfer && !last) begin
      dump_idx  <= idx_nxt;
      dump_data <= regs[idx_nxt];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reads/writes, r0 rules, same-cycle
// visibility, and dump engine with backpressure, snapshot and mid-dump reset.
`timescale 1ns/1ps
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wr_addr, dump_idx;
  logic [31:0] rs_data, rt_data, wr_data, dump_data;
  logic        we, dump_start, dump_valid, dump_ready, dump_busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [32];
  logic [36:0] sb [$];

  register_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd2(input logic [4:0] a, input logic [4:0] b, input string tag);
    rs_addr = a;
    rt_addr = b;
    #1;
    check({tag, "_rs"}, rs_data, model[a]);
    check({tag, "_rt"}, rt_data, model[b]);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    we = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  task automatic load_sb();
    sb.delete();
    for (int n = 0; n < 32; n++) sb.push_back({5'(n), model[n]});
  endtask

  task automatic check_dump_idle(input string tag);
    check({tag, "_valid"}, 32'(dump_valid), 32'd0);
    check({tag, "_busy"},  32'(dump_busy),  32'd0);
    check({tag, "_idx"},   32'(dump_idx),   32'd0);
    check({tag, "_data"},  dump_data,       32'd0);
  endtask

  // Called at a falling edge; hook 4 = snapshot writes while idx 4 stalls, hook 10 = reset at idx 10.
  task automatic dump_run(input bit toggle, input int hook, input string tag);
    int hk = 0;
    dump_start = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (sb.size() == 0) break;
      dump_ready = toggle ? !cyc[0] : 1'b1;
      dump_start = (cyc == 3);
      we = 1'b0;
      if (hook == 4 && sb[0][36:32] == 5'd4 && hk < 2) begin
        dump_ready = 1'b0;
        we = 1'b1;
        wr_addr = (hk == 0) ? 5'd4 : 5'd20;
        wr_data = (hk == 0) ? 32'hFFFF0000 : 32'hCAFEF00D;
        model[wr_addr] = wr_data;
        hk++;
      end
      if (hook == 10 && sb[0][36:32] == 5'd10) begin
        rst = 1'b1; dump_ready = 1'b0; dump_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_dump_idle({tag, "_rstabort"});
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        sb.delete();
        rd2(5'd10, 5'd31, {tag, "_rstregs"});
        rd2(5'd4, 5'd20, {tag, "_rstregs2"});
        return;
      end
      #1;
      check({tag, "_valid"}, 32'(dump_valid), 32'd1);
      check({tag, "_idx"},   32'(dump_idx),   32'(sb[0][36:32]));
      check({tag, "_data"},  dump_data,       sb[0][31:0]);
      if (dump_ready) void'(sb.pop_front());
      @(negedge clk);
    end
    we = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
    check({tag, "_remaining"}, 32'(sb.size()), 32'd0);
    #1;
    check({tag, "_done_busy"},  32'(dump_busy),  32'd1);
    check({tag, "_done_valid"}, 32'(dump_valid), 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_idle_busy"}, 32'(dump_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0; rs_addr = '0; rt_addr = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    @(negedge clk);
    rst = 1'b0;
    #1;
    check_dump_idle("reset_dump");
    rd2(5'd5, 5'd31, "reset_rd");

    @(negedge clk);
    wr(5'd8, 32'hDEADBEEF);
    rd2(5'd8, 5'd0, "wr8");
    wr(5'd0, 32'h12345678);
    rd2(5'd0, 5'd0, "wr0");

    @(negedge clk);
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5; rs_addr = 5'd9; rt_addr = 5'd8;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("samecyc_rs", rs_data, 32'hA5A5A5A5);
`else
    check("samecyc_rs", rs_data, 32'h00000000);
`endif
    check("samecyc_rt", rt_data, 32'hDEADBEEF);
    @(negedge clk);
    we = 1'b0;
    model[9] = 32'hA5A5A5A5;
    #1;
    check("nextcyc_rs", rs_data, 32'hA5A5A5A5);

    @(negedge clk);
    for (int n = 1; n < 32; n++) wr(5'(n), 32'(n * 32'h11));
    rd2(5'd17, 5'd31, "preload");
    check("preload_const", rt_data, 32'h0000020F);

    load_sb();
    dump_run(1'b1, 0, "dump_bp");

    load_sb();
    sb[20][31:0] = 32'hCAFEF00D;
    dump_run(1'b0, 4, "dump_snap");
    check("snap_r4_const", sb.size() == 0 ? 32'd0 : 32'd1, 32'd0);
    rd2(5'd4, 5'd20, "snap_regs");

    load_sb();
    dump_run(1'b1, 10, "dump_rst");
    load_sb();
    dump_run(1'b0, 0, "dump_restart");

    @(negedge clk);
    wr(5'd3, 32'h00000077);
    rst = 1'b1; we = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFFFFFF; rs_addr = 5'd3; rt_addr = 5'd0;
    #1;
    check("rst_we_nobypass", rs_data, 32'h00000077);
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    rd2(5'd3, 5'd0, "rst_we");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
